// File: rtl/secim_hakem_pkg.sv
// Shared definitions for the secim_hakem operand-mux arbiter: state encodings,
// slot geometry and a one-hot helper.
package secim_hakem_pkg;

  localparam int SLOT_COUNT = 32;
  localparam int IDX_W      = 5;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SETTLE_WAIT = 2'd1,
    ISSUE       = 2'd2
  } state_t;

  function automatic logic [SLOT_COUNT-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(SLOT_COUNT-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/secim_oncelik_kodlayici.sv
// 32-bit rotating priority encoder: the first set request at or after 'start'
// (wrapping 31->0) wins.
module secim_oncelik_kodlayici
  import secim_hakem_pkg::*;
(
  input  logic [SLOT_COUNT-1:0] req,
  input  logic [IDX_W-1:0]      start,
  output logic [IDX_W-1:0]      winner,
  output logic                  any
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest set request overwrites last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
      idx = start + IDX_W'(i);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end else begin
        any    = any;
      end
    end
  end

endmodule

// File: rtl/secim_hakem.sv
// Arbiter/sequencer for the shared 32-to-1 ALU operand mux.
// Define SECIM_HAKEM_RR_EN for round-robin arbitration; otherwise lowest index wins.
module secim_hakem
  import secim_hakem_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SLOT_COUNT-1:0] req,
  input  logic                  alu_ready,
  output logic [IDX_W-1:0]      sel,
  output logic [SLOT_COUNT-1:0] grant,
  output logic                  alu_valid,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      done_idx
);

  localparam logic [3:0] SETTLE_M1 = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t                state, state_next;
  logic [3:0]            count, count_next;
  logic [IDX_W-1:0]      sel_next, done_idx_next, start, winner;
  logic [SLOT_COUNT-1:0] grant_next;
  logic                  done_next, any;

`ifdef SECIM_HAKEM_RR_EN
  logic [IDX_W-1:0] ptr, ptr_next;
  assign start = ptr;
`else
  assign start = '0;
`endif

  secim_oncelik_kodlayici u_kodlayici (
    .req    (req),
    .start  (start),
    .winner (winner),
    .any    (any)
  );

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_next    = state;
    count_next    = count;
    sel_next      = sel;
    grant_next    = grant;
    done_next     = 1'b0;
    done_idx_next = done_idx;
`ifdef SECIM_HAKEM_RR_EN
    ptr_next      = ptr;
`endif
    case (state)
      IDLE: begin
        if (any) begin
          sel_next   = winner;
          grant_next = onehot(winner);
          if (SETTLE == 0) begin
            state_next = ISSUE;
          end else begin
            state_next = SETTLE_WAIT;
            count_next = SETTLE_M1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SETTLE_WAIT: begin
        if (count == 4'd0) begin
          state_next = ISSUE;
        end else begin
          count_next = count - 4'd1;
        end
      end
      ISSUE: begin
        if (alu_ready) begin
          state_next    = IDLE;
          grant_next    = '0;
          done_next     = 1'b1;
          done_idx_next = sel;
`ifdef SECIM_HAKEM_RR_EN
          ptr_next      = sel + 5'd1;
`endif
        end else begin
          state_next = ISSUE;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 4'd0;
      sel       <= '0;
      grant     <= '0;
      alu_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_idx  <= '0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      sel       <= sel_next;
      grant     <= grant_next;
      alu_valid <= (state_next == ISSUE);
      busy      <= (state_next != IDLE);
      done      <= done_next;
      done_idx  <= done_idx_next;
    end
  end

`ifdef SECIM_HAKEM_RR_EN
  // Round-robin pointer; advances only on a completed handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end
`endif

endmodule

// File: doc/secim_hakem.md
# secim_hakem

Round-robin arbiter and sequencer for the shared 32-to-1 operand multiplexer that feeds the ALU. Up to 32 requesters, one per operand slot A0,B0,A1,B1,…,A15,B15 (slot indices 0…31), each compete for the mux. The block drives the 5-bit mux select, waits a configurable settle time, then hands the selected operand to the ALU with a valid/ready handshake. It sits between the requester logic and the 32-way mux/ALU pair at the datapath top level.

## Interface
- SETTLE, default 1: cycles between select change and alu_valid assertion; legal range 0…15.
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  32  request per slot; bit k = slot k.
- alu_ready  in  1  ALU accepts the current operand.
- sel  out  5  binary slot index; sel[4] drives en5 (half select), sel[3:0] drives {en4,en3,en2,en1} (en4 MSB).
- grant  out  32  one-hot grant, bit k = slot k; all-zero when idle.
- alu_valid  out  1  operand on mux output is stable and offered to ALU.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after a completed handshake.
- done_idx  out  5  slot index of the transaction completed; valid while done=1.

## Operation
- States: IDLE, SETTLE_WAIT, ISSUE.
- IDLE: if req≠0 at a clock edge, pick winner, load sel/grant, go SETTLE_WAIT (SETTLE≥1) or ISSUE (SETTLE=0). If req=0 stay IDLE.
- SETTLE_WAIT: 4-bit down-counter loaded with SETTLE−1 on entry; at count 0 go ISSUE.
- ISSUE: alu_valid=1; on edge with alu_ready=1 → IDLE, grant=0, sel holds last value, done=1 for one cycle, done_idx=winner.
- Grant, sel held for the whole transaction regardless of req changes; dropping req after grant does not abort.
- Round-robin: pointer p (5 bits) = last winner+1 mod 32, wraps 31→0; search from p upward with wrap. Pointer updates on handshake only.
- Reset: state IDLE, sel=0, grant=0, alu_valid=0, busy=0, done=0, done_idx=0, p=0, counter=0. Reset mid-transaction aborts it; no done pulse.

## Timing
- Request seen at edge E0 → grant/sel valid after E0; alu_valid after E0+SETTLE.
- Handshake at edge Eh → done high for Eh…Eh+1; earliest next grant at Eh+1 (one idle bubble between transactions).
- alu_ready while alu_valid=0 is ignored.
- Outputs are all registered; no combinational path from req or alu_ready to any output.

## Configuration
- SECIM_HAKEM_RR_EN defined: round-robin arbitration as above.
- Not defined: fixed priority, lowest set req index wins; pointer logic removed, done/done_idx unchanged.

## Structure
- Shared package/header: state encodings (IDLE=2'd0, SETTLE_WAIT=2'd1, ISSUE=2'd2), slot count 32, index width 5.
- One sub-module: secim_oncelik_kodlayici — 32-bit rotating priority encoder (request vector, start index → winner index, any flag); start tied to 0 when SECIM_HAKEM_RR_EN is undefined.

## Test plan
- Reset mid-ISSUE (req[5]=1, SETTLE=1, rst at cycle 3) → all outputs 0 next cycle, no done, next grant starts search at slot 0.
- Single req[7]=1, SETTLE=2, alu_ready=1 → sel=7, grant=0x80 after E0; alu_valid at E0+2; done with done_idx=7 one cycle after handshake.
- req=0xFFFFFFFF held, alu_ready=1, RR_EN on → winners 0,1,2,…,31,0 in order, one bubble each.
- Same with RR_EN off → winner always 0.
- req[31] and req[0] set, pointer at 31 → 31 granted, then 0 (wrap-around).
- alu_ready low 10 cycles in ISSUE, req[3] dropped meanwhile → alu_valid/grant held, done_idx=3 on eventual ready.
